sysref_align: RTL and testbench

- Consumes the PL-domain SYSREF sample produced by the SYSREF capture stage: `sysref` is already registered on `clk` (the PL clock from the CLK104).
- Detects SYSREF rising edges and measures the SYSREF period in `clk` cycles.
- Declares lock after a run of identical periods and reports the phase within the SYSREF period.
- On an `arm` request, emits a single sync strobe aligned to the next SYSREF edge. Downstream sequencer/DAC/ADC timing logic uses this strobe as its MTS time zero.

---
 rtl/sysref_align_pkg.sv | 18 +
 rtl/sysref_period_meter.sv | 115 +++++++++++
 rtl/sysref_align.sv | 145 ++++++++++++++
 tb/tb_sysref_align.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysref_align_pkg.sv
// sysref_align_pkg: shared types and default parameter values for the
// SYSREF alignment block.
//   - arm_state_e : arm/sync strobe FSM encoding
//   - *_DEF       : default widths and lock threshold
package sysref_align_pkg;

    localparam int unsigned CNT_W_DEF      = 16;
    localparam int unsigned LOCK_COUNT_DEF = 4;
    localparam int unsigned ERR_W_DEF      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRE  = 2'd2,
        DONE  = 2'd3
    } arm_state_e;

endpackage

// File: rtl/sysref_period_meter.sv
// sysref_period_meter: SYSREF edge detect, phase/period measurement,
// period-match lock tracking and no-edge timeout detection.
// Ports:
//   clk_i, rst_i       PL clock, synchronous active-high reset
//   sysref_i           SYSREF level, already synchronous to clk_i
//   edge_o             combinational rising-edge indication
//   mismatch_o         pulse: measured period differs from the previous one
//   timeout_o          pulse: phase counter just reached saturation
//   locked_o           LOCK_COUNT consecutive matching periods seen
//   period_valid_o     period_o holds a measurement
//   period_o           last measured period in cycles
//   phase_o            cycles since last edge, saturating
module sysref_period_meter
    import sysref_align_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sysref_i,
    output logic             edge_o,
    output logic             mismatch_o,
    output logic             timeout_o,
    output logic             locked_o,
    output logic             period_valid_o,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] phase_o
);

    localparam logic [CNT_W-1:0] PH_MAX = '1;
    localparam logic [CNT_W-1:0] PH_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       LOCK_N = 4'(LOCK_COUNT);

    logic             s_q;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             seen_q, seen_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic [3:0]       match_q, match_d;
    logic             edge_w, tout_w, mis_w;
    logic [CNT_W-1:0] meas_w;

    always_comb begin
        edge_w  = sysref_i & ~s_q;
        meas_w  = phase_q + PH_ONE;
        // Fires once, on the increment that lands on saturation; an edge in
        // the same cycle takes precedence.
        tout_w  = ~edge_w & (phase_q == (PH_MAX - PH_ONE));
        mis_w   = edge_w & valid_q & (meas_w != period_q);

        phase_d  = phase_q;
        period_d = period_q;
        seen_d   = seen_q;
        valid_d  = valid_q;
        match_d  = match_q;

        if (edge_w) begin
            phase_d = '0;
        end else if (phase_q != PH_MAX) begin
            phase_d = phase_q + PH_ONE;
        end

        if (edge_w) begin
            seen_d = 1'b1;
            if (seen_q) begin
                period_d = meas_w;
                valid_d  = 1'b1;
            end
            if (valid_q) begin
                if (mis_w) begin
                    match_d = '0;
                end else if (match_q != LOCK_N) begin
                    match_d = match_q + 4'd1;
                end
            end
        end else if (tout_w) begin
            seen_d  = 1'b0;
            valid_d = 1'b0;
            match_d = '0;
        end

        locked_d = (match_d == LOCK_N);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_q      <= 1'b0;
            phase_q  <= '0;
            period_q <= '0;
            seen_q   <= 1'b0;
            valid_q  <= 1'b0;
            match_q  <= '0;
            locked_q <= 1'b0;
        end else begin
            s_q      <= sysref_i;
            phase_q  <= phase_d;
            period_q <= period_d;
            seen_q   <= seen_d;
            valid_q  <= valid_d;
            match_q  <= match_d;
            locked_q <= locked_d;
        end
    end

    assign edge_o         = edge_w;
    assign mismatch_o     = mis_w;
    assign timeout_o      = tout_w;
    assign locked_o       = locked_q;
    assign period_valid_o = valid_q;
    assign period_o       = period_q;
    assign phase_o        = phase_q;

endmodule

// File: rtl/sysref_align.sv
// sysref_align: measures the SYSREF period, declares lock, and on an arm
// request emits one MTS sync strobe in the cycle after the next SYSREF edge.
// Ports:
//   clk, rst        PL clock, synchronous active-high reset
//   sysref          SYSREF level, synchronous to clk
//   arm             level; each 0->1 transition requests one strobe
//   clr_err         pulse; clears err_cnt, timeout, arm_err
//   locked          period stable
//   period          last measured period; period_valid qualifies it
//   phase           cycles since last edge
//   sync_pulse      one-cycle MTS strobe
//   sync_done       strobe issued for the current arm
//   err_cnt         saturating period-mismatch count
//   timeout         sticky no-edge timeout
//   arm_err         sticky: armed while unlocked, or lock lost while armed
module sysref_align
    import sysref_align_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEF,
    parameter int unsigned ERR_W      = ERR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sysref,
    input  logic             arm,
    input  logic             clr_err,
    output logic             locked,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic [CNT_W-1:0] phase,
    output logic             sync_pulse,
    output logic             sync_done,
    output logic [ERR_W-1:0] err_cnt,
    output logic             timeout,
    output logic             arm_err
);

    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    logic             edge_w, mis_w, tout_w;
    logic             arm_q, arm_rise;
    logic             arm_err_set;
    arm_state_e       state_q, state_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             tout_q, tout_d;
    logic             aerr_q, aerr_d;

    sysref_period_meter #(
        .CNT_W      (CNT_W),
        .LOCK_COUNT (LOCK_COUNT)
    ) u_meter (
        .clk_i          (clk),
        .rst_i          (rst),
        .sysref_i       (sysref),
        .edge_o         (edge_w),
        .mismatch_o     (mis_w),
        .timeout_o      (tout_w),
        .locked_o       (locked),
        .period_valid_o (period_valid),
        .period_o       (period),
        .phase_o        (phase)
    );

    // arm history keeps tracking through reset so an arm level held across
    // reset release is not mistaken for a fresh request.
    always_ff @(posedge clk) begin
        arm_q <= arm;
    end

    assign arm_rise = arm & ~arm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        arm_err_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arm_rise) begin
                    if (locked) state_d = ARMED;
                    else        arm_err_set = 1'b1;
                end
            end
            ARMED: begin
                if (!locked) begin
                    arm_err_set = 1'b1;
                    state_d     = IDLE;
                end else if (edge_w) begin
                    state_d = FIRE;
                end
            end
            FIRE: state_d = DONE;
            DONE: if (!arm) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sync_pulse = (state_q == FIRE);
        sync_done  = (state_q == DONE);
    end

    // Sticky flags: a new set event outranks a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (mis_w) begin
            if (clr_err)           err_d = ERR_ONE;
            else if (err_q != '1)  err_d = err_q + ERR_ONE;
        end else if (clr_err) begin
            err_d = '0;
        end

        tout_d = tout_q;
        if (tout_w)       tout_d = 1'b1;
        else if (clr_err) tout_d = 1'b0;

        aerr_d = aerr_q;
        if (arm_err_set)  aerr_d = 1'b1;
        else if (clr_err) aerr_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q  <= '0;
            tout_q <= 1'b0;
            aerr_q <= 1'b0;
        end else begin
            err_q  <= err_d;
            tout_q <= tout_d;
            aerr_q <= aerr_d;
        end
    end

    assign err_cnt = err_q;
    assign timeout = tout_q;
    assign arm_err = aerr_q;

endmodule

// File: tb/tb_sysref_align.sv
// tb_sysref_align: self-checking bench for sysref_align (CNT_W=6 so the
// timeout path is reachable quickly).
module tb_sysref_align;

    localparam int unsigned CW = 6;
    localparam int unsigned LC = 4;
    localparam int unsigned EW = 8;

    logic          clk = 1'b0;
    logic          rst, sysref, arm, clr_err;
    logic          locked, period_valid, sync_pulse, sync_done, timeout, arm_err;
    logic [CW-1:0] period, phase;
    logic [EW-1:0] err_cnt;

    sysref_align #(
        .CNT_W      (CW),
        .LOCK_COUNT (LC),
        .ERR_W      (EW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sysref       (sysref),
        .arm          (arm),
        .clr_err      (clr_err),
        .locked       (locked),
        .period       (period),
        .period_valid (period_valid),
        .phase        (phase),
        .sync_pulse   (sync_pulse),
        .sync_done    (sync_done),
        .err_cnt      (err_cnt),
        .timeout      (timeout),
        .arm_err      (arm_err)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int len;
        int lk;
        int vl;
        int per;
        int err;
    } vec_t;

    vec_t tbl[13];
    vec_t exp_q[$];
    vec_t e;
    int   exp_sync_q[$];
    int   sync_exp_cyc;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input logic s);
        sysref = s;
        @(posedge clk);
        #1;
    endtask

    task automatic run_gap(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    // Every observed strobe must match a cycle the bench predicted.
    always @(negedge clk) begin
        if (sync_pulse) begin
            nchk++;
            if (exp_sync_q.size() == 0) begin
                nerr++;
                $display("FAIL sync_unexpected: got pulse at cycle %0d expected none", cyc);
            end else begin
                sync_exp_cyc = exp_sync_q.pop_front();
                if (sync_exp_cyc != cyc) begin
                    nerr++;
                    $display("FAIL sync_cycle: got %0d expected %0d", cyc, sync_exp_cyc);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_locked"},  int'(locked), 0);
        chk({tag, "_period"},  int'(period), 0);
        chk({tag, "_valid"},   int'(period_valid), 0);
        chk({tag, "_phase"},   int'(phase), 0);
        chk({tag, "_pulse"},   int'(sync_pulse), 0);
        chk({tag, "_done"},    int'(sync_done), 0);
        chk({tag, "_err"},     int'(err_cnt), 0);
        chk({tag, "_timeout"}, int'(timeout), 0);
        chk({tag, "_armerr"},  int'(arm_err), 0);
    endtask

    initial begin
        // len = gap to next edge; expectations are after this row's edge.
        tbl = '{
            '{8, 0, 0, 0, 0},
            '{8, 0, 1, 8, 0},
            '{8, 0, 1, 8, 0},
            '{8, 0, 1, 8, 0},
            '{8, 0, 1, 8, 0},
            '{8, 1, 1, 8, 0},
            '{9, 1, 1, 8, 0},
            '{8, 0, 1, 9, 1},
            '{8, 0, 1, 8, 2},
            '{8, 0, 1, 8, 2},
            '{8, 0, 1, 8, 2},
            '{8, 0, 1, 8, 2},
            '{8, 1, 1, 8, 2}
        };

        rst = 1'b1; sysref = 1'b0; arm = 1'b0; clr_err = 1'b0;
        repeat (3) tick(1'b0);
        chk_all_zero("reset");
        rst = 1'b0;
        tick(1'b0);

        // Periodic SYSREF: measurement, lock, mismatch and relock.
        for (int i = 0; i < 13; i++) begin
            exp_q.push_back(tbl[i]);
            tick(1'b1);
            e = exp_q.pop_front();
            chk($sformatf("row%0d_locked", i), int'(locked), e.lk);
            chk($sformatf("row%0d_valid", i), int'(period_valid), e.vl);
            if (e.vl != 0) chk($sformatf("row%0d_period", i), int'(period), e.per);
            chk($sformatf("row%0d_err", i), int'(err_cnt), e.err);
            chk($sformatf("row%0d_phase0", i), int'(phase), 0);
            run_gap(e.len - 1);
            chk($sformatf("row%0d_phase_end", i), int'(phase), e.len - 1);
        end

        // Arm mid-period while locked: one strobe after the next edge.
        tick(1'b1);
        run_gap(3);
        arm = 1'b1;
        tick(1'b0);
        chk("armed_done", int'(sync_done), 0);
        run_gap(3);
        exp_sync_q.push_back(cyc + 1);
        tick(1'b1);
        chk("strobe_pulse", int'(sync_pulse), 1);
        chk("strobe_phase", int'(phase), 0);
        tick(1'b0);
        chk("strobe_one_cycle", int'(sync_pulse), 0);
        chk("strobe_done", int'(sync_done), 1);
        for (int i = 0; i < 100; i++) tick((i % 8) == 6);
        chk("hold_done", int'(sync_done), 1);
        chk("hold_locked", int'(locked), 1);
        arm = 1'b0;
        tick(1'b0);
        chk("disarm_done", int'(sync_done), 0);

        // Armed, then SYSREF stops: timeout drops lock, arm error raised.
        tick(1'b0);
        tick(1'b1);
        run_gap(2);
        arm = 1'b1;
        run_gap(60);
        chk("pre_to_phase", int'(phase), 62);
        chk("pre_to_timeout", int'(timeout), 0);
        chk("pre_to_locked", int'(locked), 1);
        tick(1'b0);
        chk("to_timeout", int'(timeout), 1);
        chk("to_locked", int'(locked), 0);
        chk("to_valid", int'(period_valid), 0);
        chk("to_phase", int'(phase), 63);
        tick(1'b0);
        chk("to_armerr", int'(arm_err), 1);
        chk("to_done", int'(sync_done), 0);
        chk("to_phase_sat", int'(phase), 63);
        arm = 1'b0;
        tick(1'b0);

        // clr_err and arm while unlocked.
        clr_err = 1'b1;
        tick(1'b0);
        clr_err = 1'b0;
        chk("clr_armerr", int'(arm_err), 0);
        chk("clr_timeout", int'(timeout), 0);
        chk("clr_err", int'(err_cnt), 0);
        arm = 1'b1;
        tick(1'b0);
        chk("unlocked_arm_err", int'(arm_err), 1);
        chk("unlocked_arm_done", int'(sync_done), 0);
        arm = 1'b0;
        tick(1'b0);
        clr_err = 1'b1;
        arm = 1'b1;
        tick(1'b0);
        clr_err = 1'b0;
        chk("clr_vs_armerr", int'(arm_err), 1);
        arm = 1'b0;
        clr_err = 1'b1;
        tick(1'b0);
        clr_err = 1'b0;
        chk("clr_armerr2", int'(arm_err), 0);

        // Restart SYSREF: two edges before period_valid.
        tick(1'b1);
        chk("restart_e1_valid", int'(period_valid), 0);
        run_gap(7);
        tick(1'b1);
        chk("restart_e2_valid", int'(period_valid), 1);
        chk("restart_e2_period", int'(period), 8);
        run_gap(7);
        tick(1'b1);
        run_gap(9);
        tick(1'b1);
        chk("gap10_err", int'(err_cnt), 1);
        chk("gap10_period", int'(period), 10);
        run_gap(7);
        clr_err = 1'b1;
        tick(1'b1);
        clr_err = 1'b0;
        chk("clr_vs_mismatch", int'(err_cnt), 1);

        // Edge in the cycle timeout would otherwise fire: edge wins.
        run_gap(62);
        chk("edge_to_phase", int'(phase), 62);
        tick(1'b1);
        chk("edge_to_timeout", int'(timeout), 0);
        chk("edge_to_period", int'(period), 63);
        chk("edge_to_valid", int'(period_valid), 1);
        chk("edge_to_err", int'(err_cnt), 2);

        // Relock, arm, then reset while armed.
        run_gap(7);
        for (int i = 0; i < 6; i++) begin
            tick(1'b1);
            run_gap(7);
        end
        chk("relock_locked", int'(locked), 1);
        chk("relock_err", int'(err_cnt), 3);
        tick(1'b1);
        run_gap(2);
        arm = 1'b1;
        tick(1'b0);
        rst = 1'b1;
        tick(1'b0);
        chk_all_zero("midrst");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            run_gap(7);
        end
        chk("postrst_done", int'(sync_done), 0);
        chk("postrst_armerr", int'(arm_err), 0);
        chk("postrst_period", int'(period), 8);
        arm = 1'b0;
        tick(1'b0);

        chk("sync_outstanding", exp_sync_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
